// File: rtl/l2_pkg.sv
// Definitions shared between the L2 cache and its external memory arbiter.
package l2_pkg;

  localparam int unsigned L2_ADDR_W = 28;
  localparam int unsigned L2_DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/l2_mem_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer remembers which side was granted last.
module rr_arbiter2 (
  input  logic clk,
  input  logic proc_reset,
  input  logic req_i,
  input  logic req_d,
  input  logic update,
  output logic gnt_valid_c,
  output logic gnt_d_c
);

  logic last_d;

  // Under contention the side not granted last wins.
  assign gnt_valid_c = req_i | req_d;
  assign gnt_d_c     = req_d & (~req_i | ~last_d);

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      last_d <= 1'b1;
    end else if (update) begin
      last_d <= gnt_d_c;
    end
  end

endmodule

// File: rtl/l2_mem_arbiter.sv
// Arbitrates the L2 instruction-side and data-side miss/writeback ports onto
// the single external memory port, one transaction outstanding at a time.
module l2_mem_arbiter
  import l2_pkg::*;
#(
  parameter int unsigned ADDR_W = L2_ADDR_W,
  parameter int unsigned DATA_W = L2_DATA_W
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              memi_read,
  input  logic              memi_write,
  input  logic [ADDR_W-1:0] memi_addr,
  input  logic [DATA_W-1:0] memi_wdata,
  output logic [DATA_W-1:0] memi_rdata,
  output logic              memi_ready,
  input  logic              memd_read,
  input  logic              memd_write,
  input  logic [ADDR_W-1:0] memd_addr,
  input  logic [DATA_W-1:0] memd_wdata,
  output logic [DATA_W-1:0] memd_rdata,
  output logic              memd_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state;
  logic [DATA_W-1:0] rdata_i_q;
  logic [DATA_W-1:0] rdata_d_q;
  logic              gnt_valid_c;
  logic              gnt_d_c;
  logic              grant_c;

  assign grant_c = (state == IDLE) & gnt_valid_c;

  rr_arbiter2 u_rr (
    .clk         (clk),
    .proc_reset  (proc_reset),
    .req_i       (memi_read | memi_write),
    .req_d       (memd_read | memd_write),
    .update      (grant_c),
    .gnt_valid_c (gnt_valid_c),
    .gnt_d_c     (gnt_d_c)
  );

  // Completion is reported in the same cycle memory answers; a reset in that cycle drops it.
  assign memi_ready = (state == BUSY_I) & mem_ready & ~proc_reset;
  assign memd_ready = (state == BUSY_D) & mem_ready & ~proc_reset;
  assign memi_rdata = rdata_i_q;
  assign memd_rdata = rdata_d_q;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state     <= IDLE;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_i_q <= '0;
      rdata_d_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Write wins when a requester asserts read and write together.
          if (grant_c && gnt_d_c) begin
            state     <= BUSY_D;
            mem_addr  <= memd_addr;
            mem_wdata <= memd_wdata;
            mem_write <= memd_write;
            mem_read  <= memd_read & ~memd_write;
          end else if (grant_c) begin
            state     <= BUSY_I;
            mem_addr  <= memi_addr;
            mem_wdata <= memi_wdata;
            mem_write <= memi_write;
            mem_read  <= memi_read & ~memi_write;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            state     <= IDLE;
            rdata_i_q <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            state     <= IDLE;
            rdata_d_q <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Directed bench for l2_mem_arbiter: per-cycle vector table plus multi-cycle sequences.
module tb_l2_mem_arbiter;

  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;

  localparam logic [DW-1:0] IW  = {16{8'h1B}};
  localparam logic [DW-1:0] A5  = {16{8'hA5}};
  localparam logic [DW-1:0] P55 = {16{8'h55}};
  localparam logic [DW-1:0] C3C = {16{8'h3C}};
  localparam logic [DW-1:0] C77 = {16{8'h77}};

  logic          clk;
  logic          proc_reset;
  logic          memi_read, memi_write;
  logic [AW-1:0] memi_addr;
  logic [DW-1:0] memi_wdata, memi_rdata;
  logic          memi_ready;
  logic          memd_read, memd_write;
  logic [AW-1:0] memd_addr;
  logic [DW-1:0] memd_wdata, memd_rdata;
  logic          memd_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;

  int n_cmp;
  int n_err;

  l2_mem_arbiter dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .memi_read  (memi_read),
    .memi_write (memi_write),
    .memi_addr  (memi_addr),
    .memi_wdata (memi_wdata),
    .memi_rdata (memi_rdata),
    .memi_ready (memi_ready),
    .memd_read  (memd_read),
    .memd_write (memd_write),
    .memd_addr  (memd_addr),
    .memd_wdata (memd_wdata),
    .memd_rdata (memd_rdata),
    .memd_ready (memd_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          ir, iw;
    logic [AW-1:0] ia;
    logic          dr, dw;
    logic [AW-1:0] da;
    logic [DW-1:0] dwd;
    logic          mrdy;
    logic [DW-1:0] mrd;
    logic          e_mr, e_mw;
    logic [AW-1:0] e_ma;
    logic [DW-1:0] e_mwd;
    logic          e_irdy, e_drdy;
    logic [DW-1:0] e_ird, e_drd;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(
    input logic ir, input logic iw, input logic [AW-1:0] ia,
    input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dwd,
    input logic mrdy, input logic [DW-1:0] mrd,
    input logic e_mr, input logic e_mw, input logic [AW-1:0] e_ma, input logic [DW-1:0] e_mwd,
    input logic e_irdy, input logic e_drdy, input logic [DW-1:0] e_ird, input logic [DW-1:0] e_drd);
    vec_t v;
    v.ir = ir; v.iw = iw; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.mrdy = mrdy; v.mrd = mrd;
    v.e_mr = e_mr; v.e_mw = e_mw; v.e_ma = e_ma; v.e_mwd = e_mwd;
    v.e_irdy = e_irdy; v.e_drdy = e_drdy; v.e_ird = e_ird; v.e_drd = e_drd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    memi_read = 1'b0; memi_write = 1'b0; memi_addr = '0;
    memd_read = 1'b0; memd_write = 1'b0; memd_addr = '0; memd_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    proc_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 proc_reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    memi_read = v.ir; memi_write = v.iw; memi_addr = v.ia;
    memd_read = v.dr; memd_write = v.dw; memd_addr = v.da; memd_wdata = v.dwd;
    mem_ready = v.mrdy; mem_rdata = v.mrd;
    #1;
    chk({p, " mem_read"},   DW'(mem_read),   DW'(v.e_mr));
    chk({p, " mem_write"},  DW'(mem_write),  DW'(v.e_mw));
    chk({p, " mem_addr"},   DW'(mem_addr),   DW'(v.e_ma));
    chk({p, " mem_wdata"},  mem_wdata,       v.e_mwd);
    chk({p, " memi_ready"}, DW'(memi_ready), DW'(v.e_irdy));
    chk({p, " memd_ready"}, DW'(memd_ready), DW'(v.e_drdy));
    chk({p, " memi_rdata"}, memi_rdata,      v.e_ird);
    chk({p, " memd_rdata"}, memd_rdata,      v.e_drd);
    step();
  endtask

  initial begin
    logic got;
    logic exp_d;
    n_cmp = 0;
    n_err = 0;
    memi_wdata = IW;

    //               ir iw ia       dr dw da       dwd  rdy rdata  mr mw ma       mwd  ir dr ird  drd
    vecs[0]  = mk(0, 0, 28'h000, 0, 0, 28'h00, '0,  0, '0,   0, 0, 28'h000, '0,  0, 0, '0,  '0);
    vecs[1]  = mk(1, 0, 28'h123, 0, 0, 28'h00, '0,  0, '0,   0, 0, 28'h000, '0,  0, 0, '0,  '0);
    vecs[2]  = mk(1, 0, 28'h123, 0, 0, 28'h00, '0,  0, '0,   1, 0, 28'h123, IW,  0, 0, '0,  '0);
    vecs[3]  = mk(1, 0, 28'h123, 0, 0, 28'h00, '0,  0, '0,   1, 0, 28'h123, IW,  0, 0, '0,  '0);
    vecs[4]  = mk(1, 0, 28'h123, 0, 0, 28'h00, '0,  1, A5,   1, 0, 28'h123, IW,  1, 0, '0,  '0);
    vecs[5]  = mk(0, 0, 28'h000, 0, 0, 28'h00, '0,  0, '0,   0, 0, 28'h123, IW,  0, 0, A5,  '0);
    vecs[6]  = mk(0, 0, 28'h000, 0, 1, 28'h20, P55, 0, '0,   0, 0, 28'h123, IW,  0, 0, A5,  '0);
    vecs[7]  = mk(0, 0, 28'h000, 0, 1, 28'h20, P55, 0, '0,   0, 1, 28'h020, P55, 0, 0, A5,  '0);
    vecs[8]  = mk(0, 0, 28'h000, 0, 1, 28'h20, P55, 1, C3C,  0, 1, 28'h020, P55, 0, 1, A5,  '0);
    vecs[9]  = mk(0, 0, 28'h000, 0, 0, 28'h00, '0,  0, '0,   0, 0, 28'h020, P55, 0, 0, A5,  C3C);
    vecs[10] = mk(0, 0, 28'h000, 0, 0, 28'h00, '0,  1, C77,  0, 0, 28'h020, P55, 0, 0, A5,  C3C);
    vecs[11] = mk(0, 0, 28'h000, 0, 0, 28'h00, '0,  0, '0,   0, 0, 28'h020, P55, 0, 0, A5,  C3C);
    vecs[12] = mk(0, 0, 28'h000, 1, 1, 28'h40, P55, 0, '0,   0, 0, 28'h020, P55, 0, 0, A5,  C3C);
    vecs[13] = mk(0, 0, 28'h000, 1, 1, 28'h40, P55, 0, '0,   0, 1, 28'h040, P55, 0, 0, A5,  C3C);
    vecs[14] = mk(0, 0, 28'h000, 1, 1, 28'h40, P55, 1, C77,  0, 1, 28'h040, P55, 0, 1, A5,  C3C);
    vecs[15] = mk(0, 0, 28'h000, 0, 0, 28'h00, '0,  0, '0,   0, 0, 28'h040, P55, 0, 0, A5,  C77);
    vecs[16] = mk(0, 0, 28'h000, 0, 1, 28'h20, P55, 0, '0,   0, 0, 28'h040, P55, 0, 0, A5,  C77);
    vecs[17] = mk(0, 0, 28'h000, 0, 0, 28'h30, P55, 0, '0,   0, 1, 28'h020, P55, 0, 0, A5,  C77);
    vecs[18] = mk(0, 0, 28'h000, 0, 0, 28'h30, P55, 1, C3C,  0, 1, 28'h020, P55, 0, 1, A5,  C77);
    vecs[19] = mk(0, 0, 28'h000, 0, 0, 28'h00, '0,  0, '0,   0, 0, 28'h020, P55, 0, 0, A5,  C3C);

    do_reset();
    for (int i = 0; i < 20; i++) apply(i, vecs[i]);

    // Simultaneous first requests after reset: I first, one bubble, then D write.
    do_reset();
    memi_read = 1'b1; memi_addr = 28'h10;
    memd_write = 1'b1; memd_addr = 28'h20; memd_wdata = P55;
    step();
    chk("sim I strobe", DW'({mem_read, mem_write}), DW'(2'b10));
    chk("sim I addr", DW'(mem_addr), DW'(28'h10));
    mem_ready = 1'b1; mem_rdata = C3C;
    #1;
    chk("sim I ready", DW'({memi_ready, memd_ready}), DW'(2'b10));
    step();
    memi_read = 1'b0; mem_ready = 1'b0;
    #1;
    chk("sim bubble", DW'({mem_read, mem_write}), DW'(2'b00));
    step();
    chk("sim D strobe", DW'({mem_read, mem_write}), DW'(2'b01));
    chk("sim D addr", DW'(mem_addr), DW'(28'h20));
    chk("sim D wdata", mem_wdata, P55);
    mem_ready = 1'b1; mem_rdata = C77;
    #1;
    chk("sim D ready", DW'({memi_ready, memd_ready}), DW'(2'b01));
    step();
    idle_inputs();

    // Continuous contention: grants alternate I, D, I, D, I, D.
    do_reset();
    memi_read = 1'b1; memi_addr = 28'h100;
    memd_read = 1'b1; memd_addr = 28'h200;
    for (int k = 0; k < 6; k++) begin
      exp_d = k[0];
      got = 1'b0;
      for (int w = 0; w < 4 && !got; w++) begin
        if (mem_read) got = 1'b1;
        else step();
      end
      chk($sformatf("rr%0d strobe seen", k), DW'(got), DW'(1'b1));
      chk($sformatf("rr%0d addr", k), DW'(mem_addr), exp_d ? DW'(28'h200) : DW'(28'h100));
      mem_ready = 1'b1; mem_rdata = DW'(k + 1);
      #1;
      chk($sformatf("rr%0d ready", k), DW'({memi_ready, memd_ready}), exp_d ? DW'(2'b01) : DW'(2'b10));
      step();
      mem_ready = 1'b0;
      #1;
      chk($sformatf("rr%0d rdata", k), exp_d ? memd_rdata : memi_rdata, DW'(k + 1));
    end

    // Reset during an outstanding I transaction drops it; D afterwards proceeds normally.
    memd_read = 1'b0; memi_addr = 28'h50;
    step();
    chk("rst pre strobe", DW'(mem_read), DW'(1'b1));
    chk("rst pre addr", DW'(mem_addr), DW'(28'h50));
    proc_reset = 1'b1; memi_read = 1'b0;
    #1;
    chk("rst no ready", DW'({memi_ready, memd_ready}), DW'(2'b00));
    step();
    chk("rst strobes", DW'({mem_read, mem_write}), DW'(2'b00));
    chk("rst addr", DW'(mem_addr), DW'(0));
    chk("rst wdata", mem_wdata, DW'(0));
    chk("rst irdata", memi_rdata, DW'(0));
    chk("rst drdata", memd_rdata, DW'(0));
    proc_reset = 1'b0;
    memd_read = 1'b1; memd_addr = 28'h60;
    step();
    chk("post rst D strobe", DW'({mem_read, mem_write}), DW'(2'b10));
    chk("post rst D addr", DW'(mem_addr), DW'(28'h60));
    mem_ready = 1'b1; mem_rdata = A5;
    #1;
    chk("post rst D ready", DW'({memi_ready, memd_ready}), DW'(2'b01));
    step();
    idle_inputs();
    #1;
    chk("post rst D rdata", memd_rdata, A5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
